// File: rtl/baser_pkg.sv
// Shared 10GBASE-R constants and types for the transmit net queue.
//   SYNC_DATA / SYNC_CTRL : 66b sync header values
//   BLOCK_TYPE_CTRL       : block type byte of an all-idle control block
//   PAUSE_MARKER          : block type byte that must never enter the queue
//   IDLE_BLOCK            : payload sent when the queue underruns
package baser_pkg;

  localparam logic [1:0]  SYNC_DATA       = 2'b10;
  localparam logic [1:0]  SYNC_CTRL       = 2'b01;
  localparam logic [7:0]  BLOCK_TYPE_CTRL = 8'h1e;
  localparam logic [7:0]  PAUSE_MARKER    = 8'h77;
  localparam logic [63:0] IDLE_BLOCK      = {56'h0, BLOCK_TYPE_CTRL};

  typedef struct packed {
    logic [1:0]  hdr;
    logic [63:0] data;
  } block_t;

  // Pause markers are control blocks whose type byte is PAUSE_MARKER.
  function automatic logic is_pause_marker(input logic [1:0] hdr, input logic [7:0] type_byte);
    return (hdr == SYNC_CTRL) && (type_byte == PAUSE_MARKER);
  endfunction

endpackage

// File: rtl/tx_netq_fifo_if.sv
// Bundle of the encoder-side write port, scrambler-side read port and
// status outputs of the transmit net queue.
//   master : encoder/scrambler/monitor side (drives writes and out_ready)
//   slave  : the queue itself
interface tx_netq_fifo_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int DEPTH_LOG2 = 5,
  parameter int CNT_WIDTH  = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic [HDR_WIDTH-1:0]  in_hdr;
  logic                  in_write;
  logic [DATA_WIDTH-1:0] out_data;
  logic [HDR_WIDTH-1:0]  out_hdr;
  logic                  out_ready;
  logic                  tx_pause;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  drop_count;
  logic [CNT_WIDTH-1:0]  idle_count;

  modport master (
    output in_data, in_hdr, in_write, out_ready,
    input  out_data, out_hdr, tx_pause, level, overflow, drop_count, idle_count
  );

  modport slave (
    input  in_data, in_hdr, in_write, out_ready,
    output out_data, out_hdr, tx_pause, level, overflow, drop_count, idle_count
  );
endinterface

// File: rtl/netq_ram.sv
// Storage array for the net queue: synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : combinational read data
module netq_ram #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 66
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read sees the pre-edge contents, so a same-cycle write to the head slot
  // (full with push and pop) still returns the old block.
  assign rdata = mem[raddr];
endmodule

// File: rtl/tx_netq_fifo.sv
// Transmit net queue between the 10GBASE-R encoder and the scrambler.
// Buffers 66b blocks on in_write, emits one block per out_ready cycle
// (idle control blocks on underrun) and drives tx_pause with hysteresis.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : tx_netq_fifo_if.slave (write port, read port, status)
// Optional build macro TX_NETQ_STATS_EN enables drop_count / idle_count;
// without it both counters read 0.
module tx_netq_fifo
  import baser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int DEPTH_LOG2 = 5,
  parameter int PAUSE_HI   = 24,
  parameter int PAUSE_LO   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  tx_netq_fifo_if.slave  bus
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(1 << DEPTH_LOG2);
  localparam logic [LW-1:0] HI_L    = LW'(PAUSE_HI);
  localparam logic [LW-1:0] LO_L    = LW'(PAUSE_LO);

  logic [DEPTH_LOG2-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]                   level_reg, level_next;
  logic [DATA_WIDTH-1:0]           out_data_reg;
  logic [HDR_WIDTH-1:0]            out_hdr_reg;
  logic                            pause_reg, overflow_reg;
  logic [DATA_WIDTH+HDR_WIDTH-1:0] head;
  logic                            empty, full, accept, push, pop, drop;

  assign empty  = (level_reg == '0);
  assign full   = (level_reg == DEPTH_L);
  assign accept = bus.in_write && !is_pause_marker(bus.in_hdr, bus.in_data[7:0]);
  // Pop only drains stored entries; a pop request on empty is idle insertion.
  assign pop    = bus.out_ready && !empty;
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_comb begin
    level_next = level_reg;
    if (push && !pop)      level_next = level_reg + 1'b1;
    else if (pop && !push) level_next = level_reg - 1'b1;
  end

  netq_ram #(.ADDR_WIDTH(DEPTH_LOG2), .WIDTH(DATA_WIDTH + HDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata ({bus.in_hdr, bus.in_data}),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      out_data_reg <= DATA_WIDTH'(IDLE_BLOCK);
      out_hdr_reg  <= SYNC_CTRL;
      pause_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
      if (bus.out_ready) begin
        if (!empty) begin
          {out_hdr_reg, out_data_reg} <= head;
        end else begin
          out_hdr_reg  <= SYNC_CTRL;
          out_data_reg <= DATA_WIDTH'(IDLE_BLOCK);
        end
      end
      // Between the thresholds the previous pause state is held.
      if (level_next >= HI_L)      pause_reg <= 1'b1;
      else if (level_next <= LO_L) pause_reg <= 1'b0;
      if (drop) overflow_reg <= 1'b1;
    end
  end

`ifdef TX_NETQ_STATS_EN
  logic [CNT_WIDTH-1:0] drop_count_reg, idle_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count_reg <= '0;
      idle_count_reg <= '0;
    end else begin
      if (drop && (drop_count_reg != '1)) drop_count_reg <= drop_count_reg + 1'b1;
      if (bus.out_ready && empty && (idle_count_reg != '1))
        idle_count_reg <= idle_count_reg + 1'b1;
    end
  end

  assign bus.drop_count = drop_count_reg;
  assign bus.idle_count = idle_count_reg;
`else
  assign bus.drop_count = '0;
  assign bus.idle_count = '0;
`endif

  assign bus.out_data = out_data_reg;
  assign bus.out_hdr  = out_hdr_reg;
  assign bus.tx_pause = pause_reg;
  assign bus.level    = level_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_tx_netq_fifo.sv
// Self-checking bench for tx_netq_fifo: queue-based reference model compared
// every cycle, plus hand-computed literal expectations per scenario.
module tb_tx_netq_fifo;
  import baser_pkg::*;

  localparam int DW = 64;
  localparam int HW = 2;
  localparam int DL = 5;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tx_netq_fifo_if #(.DATA_WIDTH(DW), .HDR_WIDTH(HW), .DEPTH_LOG2(DL), .CNT_WIDTH(CW)) bus ();

  tx_netq_fifo #(
    .DATA_WIDTH(DW), .HDR_WIDTH(HW), .DEPTH_LOG2(DL),
    .PAUSE_HI(24), .PAUSE_LO(8), .CNT_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [65:0] q[$];
  logic [63:0] m_out_data;
  logic [1:0]  m_out_hdr;
  logic        m_pause;
  logic        m_ovf;
  int          m_drop;
  int          m_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out_data = IDLE_BLOCK;
    m_out_hdr  = SYNC_CTRL;
    m_pause    = 1'b0;
    m_ovf      = 1'b0;
    m_drop     = 0;
    m_idle     = 0;
  endtask

  task automatic model_update(input logic w, input logic [1:0] h, input logic [63:0] d, input logic r);
    int  sz;
    bit  popped;
    bit  marker;
    sz     = q.size();
    popped = r && (sz > 0);
    marker = (h == SYNC_CTRL) && (d[7:0] == PAUSE_MARKER);
    if (r) begin
      if (sz > 0) begin
        {m_out_hdr, m_out_data} = q.pop_front();
      end else begin
        m_out_hdr  = SYNC_CTRL;
        m_out_data = IDLE_BLOCK;
        m_idle++;
      end
    end
    if (w && !marker) begin
      if (sz < 32 || popped) q.push_back({h, d});
      else begin
        m_ovf = 1'b1;
        m_drop++;
      end
    end
    if (q.size() >= 24)     m_pause = 1'b1;
    else if (q.size() <= 8) m_pause = 1'b0;
  endtask

  task automatic compare_all();
    int exp_drop;
    int exp_idle;
`ifdef TX_NETQ_STATS_EN
    exp_drop = m_drop;
    exp_idle = m_idle;
`else
    exp_drop = 0;
    exp_idle = 0;
`endif
    chk("level",      64'(bus.level),      64'(q.size()));
    chk("tx_pause",   64'(bus.tx_pause),   64'(m_pause));
    chk("overflow",   64'(bus.overflow),   64'(m_ovf));
    chk("out_data",   bus.out_data,        m_out_data);
    chk("out_hdr",    64'(bus.out_hdr),    64'(m_out_hdr));
    chk("drop_count", 64'(bus.drop_count), 64'(exp_drop));
    chk("idle_count", 64'(bus.idle_count), 64'(exp_idle));
  endtask

  // One transaction per clock: compare at negedge, drive, then advance model.
  task automatic step(input logic w, input logic [1:0] h, input logic [63:0] d, input logic r);
    @(negedge clk);
    compare_all();
    bus.in_write  = w;
    bus.in_hdr    = h;
    bus.in_data   = d;
    bus.out_ready = r;
    $display("txn t=%0t w=%0b hdr=%b data=%h rdy=%0b | level=%0d pause=%0b out=%b_%h",
             $time, w, h, d, r, bus.level, bus.tx_pause, bus.out_hdr, bus.out_data);
    @(posedge clk);
    model_update(w, h, d, r);
    #1;
  endtask

  task automatic wr(input logic [63:0] d);
    step(1'b1, SYNC_DATA, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, SYNC_DATA, 64'h0, 1'b1);
  endtask

  initial begin
    bus.in_write  = 1'b0;
    bus.in_hdr    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;

    // Reset state
    chk("rst_out_data", bus.out_data, 64'h1e);
    chk("rst_out_hdr",  64'(bus.out_hdr), 64'h1);
    chk("rst_level",    64'(bus.level), 64'h0);

    // Basic FIFO
    for (int i = 1; i <= 5; i++) wr(64'(i));
    chk("basic_level5", 64'(bus.level), 64'd5);
    for (int i = 1; i <= 5; i++) begin
      rd();
      chk("basic_data", bus.out_data, 64'(i));
      chk("basic_hdr",  64'(bus.out_hdr), 64'h2);
    end
    for (int i = 1; i <= 2; i++) begin
      rd();
      chk("basic_idle_data", bus.out_data, 64'h1e);
      chk("basic_idle_hdr",  64'(bus.out_hdr), 64'h1);
`ifdef TX_NETQ_STATS_EN
      chk("basic_idle_cnt", 64'(bus.idle_count), 64'(i));
`endif
    end

    // Pause hysteresis
    for (int i = 0; i < 23; i++) wr(64'(100 + i));
    chk("pause_at23", 64'(bus.tx_pause), 64'h0);
    wr(64'd123);
    chk("pause_at24", 64'(bus.tx_pause), 64'h1);
    for (int i = 0; i < 15; i++) rd();
    chk("pause_lvl9",  64'(bus.level), 64'd9);
    chk("pause_at9",   64'(bus.tx_pause), 64'h1);
    rd();
    chk("pause_at8",   64'(bus.tx_pause), 64'h0);
    for (int i = 0; i < 8; i++) rd();

    // Overflow
    for (int i = 0; i < 32; i++) wr(64'(200 + i));
    for (int i = 0; i < 3; i++)  wr(64'(300 + i));
    chk("ovf_level", 64'(bus.level), 64'd32);
    chk("ovf_flag",  64'(bus.overflow), 64'h1);
`ifdef TX_NETQ_STATS_EN
    chk("ovf_drops", 64'(bus.drop_count), 64'd3);
`endif

    // Full with simultaneous push and pop
    step(1'b1, SYNC_DATA, 64'd999, 1'b1);
    chk("full_rw_level", 64'(bus.level), 64'd32);
    chk("full_rw_out",   bus.out_data, 64'd200);
`ifdef TX_NETQ_STATS_EN
    chk("full_rw_drops", 64'(bus.drop_count), 64'd3);
`endif
    for (int i = 1; i < 32; i++) begin
      rd();
      chk("ovf_drain", bus.out_data, 64'(200 + i));
    end
    rd();
    chk("full_rw_new", bus.out_data, 64'd999);

    // Pause-marker filter
    wr(64'hAAAA);
    step(1'b1, SYNC_CTRL, 64'h1234_5677, 1'b0);
    chk("marker_level", 64'(bus.level), 64'd1);
    rd();
    chk("marker_a", bus.out_data, 64'hAAAA);
    rd();
    chk("marker_skip", bus.out_data, 64'h1e);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 25; i++) wr(64'(400 + i));
    rd();
    rd();
    chk("pre_rst_pause", 64'(bus.tx_pause), 64'h1);
    chk("pre_rst_ovf",   64'(bus.overflow), 64'h1);
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 64'(bus.level), 64'h0);
    chk("arst_pause", 64'(bus.tx_pause), 64'h0);
    chk("arst_ovf",   64'(bus.overflow), 64'h0);
    chk("arst_data",  bus.out_data, 64'h1e);
    model_reset();
    #9 rst_n = 1'b1;
    rd();
    chk("post_rst_idle", bus.out_data, 64'h1e);
    chk("post_rst_hdr",  64'(bus.out_hdr), 64'h1);

    @(negedge clk);
    compare_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tx_netq_fifo.md
Name: tx_netq_fifo

Overview:
- Transmit-side net queue sitting directly downstream of the 10GBASE-R encoder.
- Buffers 66-bit encoded blocks (64-bit data plus 2-bit sync header) only on cycles where the encoder's write strobe is high.
- Hands blocks to the scrambler/gearbox one per `out_ready` cycle, and fills gaps with idle control blocks when empty.
- Drives `tx_pause` back upstream with hysteresis so the MAC/encoder path throttles before overflow.

Parameters:
- DATA_WIDTH, 64, encoded block payload width; only 64 is legal.
- HDR_WIDTH, 2, sync header width; only 2 is legal.
- DEPTH_LOG2, 5, log2 of FIFO depth (32 entries).
- PAUSE_HI, 24, occupancy at or above which `tx_pause` asserts.
- PAUSE_LO, 8, occupancy at or below which `tx_pause` deasserts; must be < PAUSE_HI.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  DATA_WIDTH  encoded block from encoder.
- in_hdr  input  HDR_WIDTH  sync header from encoder.
- in_write  input  1  write strobe (encoder netq_write).
- out_data  output  DATA_WIDTH  block to scrambler.
- out_hdr  output  HDR_WIDTH  header to scrambler.
- out_ready  input  1  downstream consumes one block this cycle.
- tx_pause  output  1  backpressure to encoder/MAC.
- level  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2.
- overflow  output  1  sticky: a write was dropped while full.
- drop_count  output  CNT_WIDTH  writes dropped while full.
- idle_count  output  CNT_WIDTH  idle blocks inserted on underrun.

Behaviour:
- **Reset.** Asynchronous reset, active-low; asserting `rst_n` low clears state immediately regardless of clk.
  - Reset values: `out_data` = 64'h1e (idle control block), `out_hdr` = 2'b01, `tx_pause` = 0, `level` = 0, `overflow` = 0, both counters = 0.
  - Pointers reset to 0.
  - Reset mid-operation discards all stored blocks.
- **Storage.** Circular buffer of 2^DEPTH_LOG2 entries, each {hdr, data}. Read and write pointers are DEPTH_LOG2 bits and wrap naturally modulo depth. `level` is tracked as a separate counter.
- **Write.**
  - When `in_write` = 1, the entry is stored if not full, or if full and a pop occurs in the same cycle.
  - Defensive filter: `in_hdr` = 2'b01 with `in_data[7:0]` = 8'h77 (pause marker) is never stored or counted, even when `in_write` = 1.
  - Write when full with no simultaneous pop: entry dropped, `overflow` set (sticky until reset), `drop_count` incremented (saturating).
- **Read.** Output is registered, one-cycle latency; `out_data`/`out_hdr` change only on cycles with `out_ready` = 1.
  - `out_ready` = 1 and FIFO non-empty: the head entry is loaded into the output registers and the read pointer advances.
  - `out_ready` = 1 and FIFO empty: load the idle block (hdr 01, data {56'h0, 8'h1e}) and increment `idle_count` (saturating).
  - `out_ready` = 0: outputs hold their value.
  - A write into an empty FIFO is not visible to a pop in the same cycle; earliest emission is the cycle after the write.
- **Level update.** `level_next = level + push - pop`.
  - Simultaneous push and pop at full: level unchanged, no drop.
  - Simultaneous push and pop at empty: pop is the idle insertion, so `level_next = 1`.
- **Pause.** Hysteresis, registered from `level_next`:
  - Set when `level_next` >= PAUSE_HI.
  - Cleared when `level_next` <= PAUSE_LO.
  - Otherwise held.
- **Ordering.** FIFO order is preserved exactly; no reordering and no block modification.

Optional Feature:
- Macro: TX_NETQ_STATS_EN.
- **Defined:** `drop_count` and `idle_count` are implemented as described.
- **Undefined:** both counters are tied to 0 and no counter flops are inferred. `overflow`, dropping and idle insertion behave identically in both builds.

Decomposition:
- Shared package `baser_pkg` holds:
  - SYNC_DATA = 2'b10, SYNC_CTRL = 2'b01.
  - BLOCK_TYPE_CTRL = 8'h1e.
  - PAUSE_MARKER = 8'h77.
  - IDLE_BLOCK = 64'h1e.
- One natural sub-module: `netq_ram`, a simple dual-port array with synchronous write and asynchronous read, depth 2^DEPTH_LOG2, width 66. Pointer, level, pause and counter logic stay in `tx_netq_fifo`.

Test Plan:
- **Basic FIFO.** Release reset; write 5 data blocks (hdr 10, data 1..5) with `out_ready` = 0, then hold `out_ready` = 1 → `out_data` 1..5 in order on consecutive cycles, then 64'h1e with hdr 01; `idle_count` increments each following cycle.
- **Pause hysteresis.** `out_ready` = 0, 24 writes → `tx_pause` = 1 the cycle after level reaches 24. Drain to 9 → still 1. Drain to 8 → `tx_pause` = 0.
- **Overflow.** Fill 32 entries, then 3 more writes with `out_ready` = 0 → `level` = 32, `overflow` = 1, `drop_count` = 3. Drain → the first 32 blocks are read out unchanged.
- **Full with simultaneous read/write.** At level = 32, `in_write` = 1 and `out_ready` = 1 → `level` stays 32, `drop_count` unchanged, new block appears 32 pops later.
- **Pause-marker filter.** `in_write` = 1 with hdr 01 and data[7:0] = 8'h77 → `level` unchanged, no counter change, block never emitted.
- **Async reset.** Drop `rst_n` mid-drain, away from the clk edge → `level`, `tx_pause` and `overflow` go to 0 immediately, `out_data` = 64'h1e; the next pop after release yields an idle block.
